// File: rtl/codec_bus_slave.sv
// codec_bus_slave: memory-mapped register slave for the WM8731 codec controller.
// It buffers DAC samples on their way to the serializer and ADC samples coming
// back from the deserializer. It also holds the 24-bit I2C command word and
// launches it to the I2C engine, and it reports status through a level interrupt.

// Synchronous FIFO with first-word fall-through (the head entry is always on rdata).
module codec_bus_fifo #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;
  localparam int LW    = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  // Pointer and level bookkeeping; the pointers wrap naturally at 2^AW.
  // NOTE: every variable gets a default at the top of always_comb, so no path can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage.
  // NOTE: the storage array is deliberately not reset; clearing the pointers and level is enough to empty the FIFO.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
endmodule

module codec_bus_slave #(
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int DATA_W          = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [2:0]        slave_address,
  input  logic [31:0]       slave_writedata,
  output logic [31:0]       slave_readdata,
  input  logic              slave_chipselect,
  output logic              slave_waitrequest,
  input  logic              slave_beginbursttransfer,
  input  logic [7:0]        slave_burstcount,
  output logic              slave_irq,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  input  logic              dac_ready,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [23:0]       i2c_packet,
  output logic              i2c_start,
  input  logic              i2c_busy
);
  localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;

  localparam logic [2:0] ADDR_I2C     = 3'd0;
  localparam logic [2:0] ADDR_DAC     = 3'd1;
  localparam logic [2:0] ADDR_ADC     = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_CONTROL = 3'd4;

  logic              dac_full, dac_empty, adc_full, adc_empty;
  logic [LVL_W-1:0]  dac_level, adc_level;
  logic [DATA_W-1:0] adc_head;
  logic              access, wr_acc, rd_acc;
  logic              dac_push, dac_pop, adc_push, adc_pop, adc_drop;
  logic [31:0]       status_word;

  logic [31:0] i2c_reg_q, i2c_reg_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        ovr_q, ovr_d;
  logic        irq_q, irq_d;
  logic        start_q, start_d;
  logic [31:0] rdata_q, rdata_d;

  // Burst qualifiers are informational only; each beat is handled as a single access.
  logic unused_burst;
  assign unused_burst = ^{slave_beginbursttransfer, slave_burstcount};

  // The only stalls: pushing into a full DAC FIFO, popping an empty ADC FIFO, or writing a command while I2C is busy.
  assign slave_waitrequest = slave_chipselect &
                             ((slave_write & (slave_address == ADDR_DAC) & dac_full)  |
                              (slave_read  & (slave_address == ADDR_ADC) & adc_empty) |
                              (slave_write & (slave_address == ADDR_I2C) & i2c_busy));

  // A request with both strobes high counts as a write.
  assign access = slave_chipselect & (slave_read | slave_write) & ~slave_waitrequest;
  assign wr_acc = access & slave_write;
  assign rd_acc = access & slave_read & ~slave_write;

  assign dac_push  = wr_acc & (slave_address == ADDR_DAC);
  assign dac_pop   = dac_valid & dac_ready;
  assign dac_valid = ~dac_empty;

  // A full ADC FIFO still accepts a sample when a pop frees a slot on the same edge.
  assign adc_pop  = rd_acc & (slave_address == ADDR_ADC);
  assign adc_push = adc_valid & (~adc_full | adc_pop);
  assign adc_drop = adc_valid & adc_full & ~adc_pop;

  codec_bus_fifo #(.AW(FIFO_DEPTH_LOG2), .DW(DATA_W)) u_dac_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (dac_push),
    .pop   (dac_pop),
    .wdata (DATA_W'(slave_writedata)),
    .rdata (dac_data),
    .level (dac_level),
    .full  (dac_full),
    .empty (dac_empty)
  );

  codec_bus_fifo #(.AW(FIFO_DEPTH_LOG2), .DW(DATA_W)) u_adc_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (adc_push),
    .pop   (adc_pop),
    .wdata (adc_data),
    .rdata (adc_head),
    .level (adc_level),
    .full  (adc_full),
    .empty (adc_empty)
  );

  // Assemble the STATUS word from the live FIFO flags, I2C busy, sticky overrun and the two levels.
  always_comb begin
    status_word        = '0;
    status_word[0]     = dac_full;
    status_word[1]     = dac_empty;
    status_word[2]     = adc_full;
    status_word[3]     = adc_empty;
    status_word[4]     = i2c_busy;
    status_word[5]     = ovr_q;
    status_word[15:8]  = 8'(dac_level);
    status_word[23:16] = 8'(adc_level);
  end

  // Register-file next state: writes, sticky overrun, read-data capture and interrupt.
  always_comb begin
    i2c_reg_d = i2c_reg_q;
    ctrl_d    = ctrl_q;
    ovr_d     = ovr_q;
    rdata_d   = rdata_q;
    start_d   = wr_acc & (slave_address == ADDR_I2C);
    if (wr_acc) begin
      case (slave_address)
        ADDR_I2C:     i2c_reg_d = slave_writedata;
        ADDR_STATUS:  if (slave_writedata[5]) ovr_d = 1'b0;
        ADDR_CONTROL: ctrl_d = slave_writedata[2:0];
        default:      ;
      endcase
    end
    // A drop on the same edge as a clear wins, so no overrun event is ever lost.
    if (adc_drop) ovr_d = 1'b1;
    if (rd_acc) begin
      case (slave_address)
        ADDR_I2C:     rdata_d = i2c_reg_q;
        ADDR_ADC:     rdata_d = 32'(adc_head);
        ADDR_STATUS:  rdata_d = status_word;
        ADDR_CONTROL: rdata_d = {29'd0, ctrl_q};
        default:      rdata_d = '0;
      endcase
    end
    irq_d = (ctrl_q[0] & ~adc_empty) | (ctrl_q[1] & ~dac_full) | (ctrl_q[2] & ovr_q);
  end

  // Register-file state with synchronous reset; reset also cancels a launch pulse still to come.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      i2c_reg_q <= '0;
      ctrl_q    <= '0;
      ovr_q     <= 1'b0;
      irq_q     <= 1'b0;
      start_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      i2c_reg_q <= i2c_reg_d;
      ctrl_q    <= ctrl_d;
      ovr_q     <= ovr_d;
      irq_q     <= irq_d;
      start_q   <= start_d;
      rdata_q   <= rdata_d;
    end
  end

  assign slave_readdata = rdata_q;
  assign slave_irq      = irq_q;
  assign i2c_start      = start_q;
  assign i2c_packet     = i2c_reg_q[23:0];
endmodule

// File: tb/tb_codec_bus_slave.sv
// Testbench for codec_bus_slave. Every cycle is checked against a transaction-level
// model that keeps both FIFOs as queues and applies the register rules directly.
module tb_codec_bus_slave;
  localparam int DEPTH = 8;

  logic        Clk;
  logic        Reset;
  logic        slave_read, slave_write, slave_chipselect;
  logic [2:0]  slave_address;
  logic [31:0] slave_writedata, slave_readdata;
  logic        slave_waitrequest;
  logic        slave_beginbursttransfer;
  logic [7:0]  slave_burstcount;
  logic        slave_irq;
  logic [31:0] dac_data, adc_data;
  logic        dac_valid, dac_ready, adc_valid;
  logic [23:0] i2c_packet;
  logic        i2c_start, i2c_busy;

  int vectors;
  int miscompares;

  // Background inputs applied on each cycle; adc_valid and beginbursttransfer are strobes.
  logic        bg_dac_ready, bg_adc_valid, bg_busy, bg_bb;
  logic [31:0] bg_adc_data;
  logic [7:0]  bg_bc;

  // Reference model state.
  logic [31:0] dac_m[$];
  logic [31:0] adc_m[$];
  logic [31:0] i2c_m, rdata_m;
  logic [2:0]  ctrl_m;
  logic        ovr_m, irq_m, start_m;

  codec_bus_slave dut (
    .Clk                      (Clk),
    .Reset                    (Reset),
    .slave_read               (slave_read),
    .slave_write              (slave_write),
    .slave_address            (slave_address),
    .slave_writedata          (slave_writedata),
    .slave_readdata           (slave_readdata),
    .slave_chipselect         (slave_chipselect),
    .slave_waitrequest        (slave_waitrequest),
    .slave_beginbursttransfer (slave_beginbursttransfer),
    .slave_burstcount         (slave_burstcount),
    .slave_irq                (slave_irq),
    .dac_data                 (dac_data),
    .dac_valid                (dac_valid),
    .dac_ready                (dac_ready),
    .adc_data                 (adc_data),
    .adc_valid                (adc_valid),
    .i2c_packet               (i2c_packet),
    .i2c_start                (i2c_start),
    .i2c_busy                 (i2c_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] status_m();
    logic [31:0] s;
    s        = '0;
    s[0]     = (dac_m.size() == DEPTH);
    s[1]     = (dac_m.size() == 0);
    s[2]     = (adc_m.size() == DEPTH);
    s[3]     = (adc_m.size() == 0);
    s[4]     = bg_busy;
    s[5]     = ovr_m;
    s[15:8]  = 8'(dac_m.size());
    s[23:16] = 8'(adc_m.size());
    return s;
  endfunction

  task automatic model_reset();
    dac_m.delete();
    adc_m.delete();
    i2c_m   = '0;
    rdata_m = '0;
    ctrl_m  = '0;
    ovr_m   = 1'b0;
    irq_m   = 1'b0;
    start_m = 1'b0;
    bg_dac_ready = 1'b0;
    bg_adc_valid = 1'b0;
    bg_adc_data  = '0;
    bg_busy      = 1'b0;
    bg_bb        = 1'b0;
    bg_bc        = '0;
  endtask

  // One bus cycle: drive after the falling edge, predict, let the rising edge happen, compare at the next falling edge.
  task automatic drive_cycle(input logic rd, input logic wr, input logic [2:0] addr,
                             input logic [31:0] wd, output bit acc);
    logic        exp_wait, wa, ra, irq_next;
    logic [31:0] rval;
    slave_chipselect         = rd | wr;
    slave_read               = rd;
    slave_write              = wr;
    slave_address            = addr;
    slave_writedata          = wd;
    dac_ready                = bg_dac_ready;
    adc_valid                = bg_adc_valid;
    adc_data                 = bg_adc_data;
    i2c_busy                 = bg_busy;
    slave_beginbursttransfer = bg_bb;
    slave_burstcount         = bg_bc;
    #1;
    exp_wait = (rd | wr) && ((wr && addr == 3'd1 && dac_m.size() == DEPTH) ||
                             (rd && addr == 3'd2 && adc_m.size() == 0) ||
                             (wr && addr == 3'd0 && bg_busy));
    vectors++;
    if (slave_waitrequest !== exp_wait) begin
      miscompares++;
      $display("FAIL waitrequest addr=%0d rd=%0b wr=%0b: got %0b expected %0b",
               addr, rd, wr, slave_waitrequest, exp_wait);
    end
    acc = (rd | wr) && !exp_wait;
    wa  = acc && wr;
    ra  = acc && rd && !wr;
    case (addr)
      3'd0:    rval = i2c_m;
      3'd2:    rval = (adc_m.size() > 0) ? adc_m[0] : '0;
      3'd3:    rval = status_m();
      3'd4:    rval = {29'd0, ctrl_m};
      default: rval = '0;
    endcase
    irq_next = (ctrl_m[0] && adc_m.size() != 0) || (ctrl_m[1] && dac_m.size() != DEPTH) ||
               (ctrl_m[2] && ovr_m);
    @(posedge Clk);
    if (ra) rdata_m = rval;
    start_m = wa && addr == 3'd0;
    if (dac_m.size() > 0 && bg_dac_ready) void'(dac_m.pop_front());
    if (wa) begin
      case (addr)
        3'd0:    i2c_m = wd;
        3'd1:    dac_m.push_back(wd);
        3'd3:    if (wd[5]) ovr_m = 1'b0;
        3'd4:    ctrl_m = wd[2:0];
        default: ;
      endcase
    end
    if (ra && addr == 3'd2) void'(adc_m.pop_front());
    if (bg_adc_valid) begin
      if (adc_m.size() < DEPTH) adc_m.push_back(bg_adc_data);
      else ovr_m = 1'b1;
    end
    irq_m        = irq_next;
    bg_adc_valid = 1'b0;
    bg_bb        = 1'b0;
    @(negedge Clk);
    vectors++;
    if (slave_readdata !== rdata_m) begin
      miscompares++;
      $display("FAIL readdata: got %08h expected %08h", slave_readdata, rdata_m);
    end
    vectors++;
    if (i2c_start !== start_m || i2c_packet !== i2c_m[23:0]) begin
      miscompares++;
      $display("FAIL i2c_out: got start=%0b pkt=%06h expected start=%0b pkt=%06h",
               i2c_start, i2c_packet, start_m, i2c_m[23:0]);
    end
    vectors++;
    if (slave_irq !== irq_m) begin
      miscompares++;
      $display("FAIL irq: got %0b expected %0b", slave_irq, irq_m);
    end
    vectors++;
    if (dac_valid !== (dac_m.size() > 0)) begin
      miscompares++;
      $display("FAIL dac_valid: got %0b expected %0b", dac_valid, dac_m.size() > 0);
    end
    if (dac_m.size() > 0) begin
      vectors++;
      if (dac_data !== dac_m[0]) begin
        miscompares++;
        $display("FAIL dac_data: got %08h expected %08h", dac_data, dac_m[0]);
      end
    end
  endtask

  // Hold a request until it is accepted, within a cycle budget.
  task automatic bus_op(input logic rd, input logic wr, input logic [2:0] addr,
                        input logic [31:0] wd, input int budget);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) drive_cycle(rd, wr, addr, wd, acc);
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL bus_timeout addr=%0d: got no accept expected accept within %0d cycles", addr, budget);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 3'd0, '0, acc);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    vectors++;
    if (slave_readdata !== 32'd0 || slave_irq !== 1'b0 || dac_valid !== 1'b0 ||
        i2c_start !== 1'b0 || i2c_packet !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rd=%08h irq=%0b dv=%0b st=%0b pkt=%06h expected all zero",
               slave_readdata, slave_irq, dac_valid, i2c_start, i2c_packet);
    end
    bus_op(1'b1, 1'b0, 3'd3, '0, 2);
    vectors++;
    if (slave_readdata !== 32'h0000000A) begin
      miscompares++;
      $display("FAIL reset_status: got %08h expected 0000000a", slave_readdata);
    end
  endtask

  task automatic test_i2c();
    bus_op(1'b0, 1'b1, 3'd0, 32'h00341E00, 2);
    vectors++;
    if (i2c_packet !== 24'h341E00 || i2c_start !== 1'b1) begin
      miscompares++;
      $display("FAIL i2c_launch: got pkt=%06h start=%0b expected 341e00 1", i2c_packet, i2c_start);
    end
    idle(1);
    vectors++;
    if (i2c_start !== 1'b0) begin
      miscompares++;
      $display("FAIL i2c_pulse_width: got start=%0b expected 0", i2c_start);
    end
    bg_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bit acc;
      drive_cycle(1'b0, 1'b1, 3'd0, 32'hDEADBEEF, acc);
      vectors++;
      if (slave_waitrequest !== 1'b1 || i2c_packet !== 24'h341E00) begin
        miscompares++;
        $display("FAIL i2c_busy_stall: got wait=%0b pkt=%06h expected 1 341e00", slave_waitrequest, i2c_packet);
      end
    end
    bg_busy = 1'b0;
    bus_op(1'b0, 1'b1, 3'd0, 32'hDEADBEEF, 2);
    vectors++;
    if (i2c_packet !== 24'hADBEEF || i2c_start !== 1'b1) begin
      miscompares++;
      $display("FAIL i2c_after_busy: got pkt=%06h start=%0b expected adbeef 1", i2c_packet, i2c_start);
    end
    bus_op(1'b1, 1'b0, 3'd0, '0, 2);
    vectors++;
    if (slave_readdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL i2c_readback: got %08h expected deadbeef", slave_readdata);
    end
  endtask

  task automatic test_dac_fill();
    logic [31:0] drain_exp[9];
    bg_dac_ready = 1'b0;
    for (int i = 1; i <= 8; i++) bus_op(1'b0, 1'b1, 3'd1, 32'(i * 32'h11), 2);
    bus_op(1'b1, 1'b0, 3'd3, '0, 2);
    vectors++;
    if (slave_readdata[0] !== 1'b1 || slave_readdata[15:8] !== 8'd8 || dac_data !== 32'h11) begin
      miscompares++;
      $display("FAIL dac_full_status: got status=%08h head=%08h expected full level 8 head 11",
               slave_readdata, dac_data);
    end
    for (int i = 0; i < 3; i++) begin
      bit acc;
      drive_cycle(1'b0, 1'b1, 3'd1, 32'h99, acc);
      vectors++;
      if (slave_waitrequest !== 1'b1) begin
        miscompares++;
        $display("FAIL dac_ninth_stall: got wait=%0b expected 1", slave_waitrequest);
      end
    end
    bg_dac_ready = 1'b1;
    begin
      bit acc;
      drive_cycle(1'b0, 1'b1, 3'd1, 32'h99, acc);
    end
    bg_dac_ready = 1'b0;
    bus_op(1'b0, 1'b1, 3'd1, 32'h99, 2);
    bus_op(1'b1, 1'b0, 3'd3, '0, 2);
    vectors++;
    if (dac_data !== 32'h22 || slave_readdata[15:8] !== 8'd8 || slave_readdata[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL dac_refill: got head=%08h status=%08h expected head 22 level 8 full",
               dac_data, slave_readdata);
    end
    for (int i = 0; i < 8; i++) drain_exp[i] = 32'((i + 2) * 32'h11);
    drain_exp[7] = 32'h99;
    bg_dac_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (dac_data !== drain_exp[i] || dac_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL dac_drain[%0d]: got %08h v=%0b expected %08h v=1", i, dac_data, dac_valid, drain_exp[i]);
      end
      idle(1);
    end
    vectors++;
    if (dac_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dac_empty_after_drain: got valid=%0b expected 0", dac_valid);
    end
    bg_dac_ready = 1'b0;
  endtask

  task automatic test_adc_burst();
    bit acc;
    for (int i = 0; i < 3; i++) begin
      bg_adc_valid = 1'b1;
      bg_adc_data  = 32'hA1 + 32'(i);
      idle(1);
    end
    bg_bb = 1'b1;
    bg_bc = 8'd3;
    for (int k = 0; k < 3; k++) begin
      bus_op(1'b1, 1'b0, 3'd2, '0, 2);
      vectors++;
      if (slave_readdata !== 32'hA1 + 32'(k)) begin
        miscompares++;
        $display("FAIL adc_burst[%0d]: got %08h expected %08h", k, slave_readdata, 32'hA1 + 32'(k));
      end
    end
    bg_bc = 8'd0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0, 3'd2, '0, acc);
      vectors++;
      if (slave_waitrequest !== 1'b1) begin
        miscompares++;
        $display("FAIL adc_empty_stall: got wait=%0b expected 1", slave_waitrequest);
      end
    end
    bg_adc_valid = 1'b1;
    bg_adc_data  = 32'hA4;
    drive_cycle(1'b1, 1'b0, 3'd2, '0, acc);
    bus_op(1'b1, 1'b0, 3'd2, '0, 2);
    vectors++;
    if (slave_readdata !== 32'hA4) begin
      miscompares++;
      $display("FAIL adc_after_stall: got %08h expected 000000a4", slave_readdata);
    end
    bus_op(1'b1, 1'b0, 3'd3, '0, 2);
    vectors++;
    if (slave_readdata[3] !== 1'b1 || slave_readdata[23:16] !== 8'd0) begin
      miscompares++;
      $display("FAIL adc_empty_status: got %08h expected adc_empty set level 0", slave_readdata);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] smp[8];
    for (int i = 0; i < 8; i++) begin
      smp[i]       = $urandom() & 32'hFFFF_FF00;
      bg_adc_valid = 1'b1;
      bg_adc_data  = smp[i];
      idle(1);
    end
    bg_adc_valid = 1'b1;
    bg_adc_data  = 32'hFF;
    idle(1);
    bus_op(1'b1, 1'b0, 3'd3, '0, 2);
    vectors++;
    if (slave_readdata[5] !== 1'b1 || slave_readdata[2] !== 1'b1 || slave_readdata[23:16] !== 8'd8) begin
      miscompares++;
      $display("FAIL overrun_status: got %08h expected ovr, adc_full, level 8", slave_readdata);
    end
    bus_op(1'b0, 1'b1, 3'd4, 32'h4, 2);
    idle(1);
    vectors++;
    if (slave_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_irq: got %0b expected 1", slave_irq);
    end
    bus_op(1'b0, 1'b1, 3'd3, 32'h20, 2);
    idle(1);
    vectors++;
    if (slave_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_after_clear: got %0b expected 0", slave_irq);
    end
    bus_op(1'b1, 1'b0, 3'd3, '0, 2);
    vectors++;
    if (slave_readdata[5] !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear: got %08h expected bit5 clear", slave_readdata);
    end
    for (int i = 0; i < 8; i++) begin
      bus_op(1'b1, 1'b0, 3'd2, '0, 2);
      vectors++;
      if (slave_readdata !== smp[i]) begin
        miscompares++;
        $display("FAIL overrun_contents[%0d]: got %08h expected %08h", i, slave_readdata, smp[i]);
      end
    end
    bus_op(1'b0, 1'b1, 3'd4, 32'h0, 2);
  endtask

  task automatic test_random_traffic();
    bit acc;
    int op;
    for (int n = 0; n < 600; n++) begin
      op           = int'($urandom_range(0, 9));
      bg_dac_ready = ($urandom_range(0, 1) == 1);
      bg_adc_valid = ($urandom_range(0, 9) < 4);
      bg_adc_data  = $urandom();
      bg_busy      = ($urandom_range(0, 3) == 0);
      case (op)
        0, 1: drive_cycle(1'b0, 1'b0, 3'd0, '0, acc);
        2, 3: drive_cycle(1'b0, 1'b1, 3'd1, $urandom(), acc);
        4, 5: drive_cycle(1'b1, 1'b0, 3'd2, '0, acc);
        6: begin
          logic [2:0] a;
          a = ($urandom_range(0, 2) == 0) ? 3'd0 : (($urandom_range(0, 1) == 1) ? 3'd3 : 3'd4);
          drive_cycle(1'b1, 1'b0, a, '0, acc);
        end
        7: drive_cycle(1'b0, 1'b1, 3'd4, $urandom(), acc);
        8: drive_cycle(1'b0, 1'b1, ($urandom_range(0, 1) == 1) ? 3'd3 : 3'd0, $urandom(), acc);
        default: drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             3'($urandom_range(0, 7)), $urandom(), acc);
      endcase
    end
    bg_busy      = 1'b0;
    bg_dac_ready = 1'b1;
    for (int i = 0; i < 20 && dac_m.size() > 0; i++) idle(1);
    bg_dac_ready = 1'b0;
    for (int i = 0; i < 20 && adc_m.size() > 0; i++) bus_op(1'b1, 1'b0, 3'd2, '0, 2);
    bus_op(1'b0, 1'b1, 3'd4, 32'h0, 2);
    bus_op(1'b0, 1'b1, 3'd3, 32'h20, 2);
    idle(2);
    bus_op(1'b1, 1'b0, 3'd3, '0, 2);
    vectors++;
    if (slave_readdata !== 32'h0000000A) begin
      miscompares++;
      $display("FAIL random_settle_status: got %08h expected 0000000a", slave_readdata);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      bg_adc_valid = 1'b1;
      bg_adc_data  = 32'hC0 + 32'(i);
      idle(1);
    end
    for (int i = 0; i < 3; i++) bus_op(1'b0, 1'b1, 3'd1, 32'h500 + 32'(i), 2);
    bg_bb = 1'b1;
    bg_bc = 8'd4;
    bus_op(1'b1, 1'b0, 3'd2, '0, 2);
    bus_op(1'b1, 1'b0, 3'd2, '0, 2);
    vectors++;
    if (slave_readdata !== 32'hC1) begin
      miscompares++;
      $display("FAIL pre_reset_burst: got %08h expected 000000c1", slave_readdata);
    end
    // Reset lands on the same edge as an I2C command write, so no launch may follow.
    Reset            = 1'b1;
    slave_chipselect = 1'b1;
    slave_read       = 1'b0;
    slave_write      = 1'b1;
    slave_address    = 3'd0;
    slave_writedata  = 32'h00123456;
    i2c_busy         = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    vectors++;
    if (i2c_start !== 1'b0 || i2c_packet !== 24'd0 || slave_readdata !== 32'd0 || dac_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got st=%0b pkt=%06h rd=%08h dv=%0b expected all zero",
               i2c_start, i2c_packet, slave_readdata, dac_valid);
    end
    idle(1);
    bus_op(1'b1, 1'b0, 3'd3, '0, 2);
    vectors++;
    if (slave_readdata !== 32'h0000000A) begin
      miscompares++;
      $display("FAIL mid_reset_status: got %08h expected 0000000a", slave_readdata);
    end
  endtask

  initial begin
    vectors                  = 0;
    miscompares              = 0;
    Reset                    = 1'b1;
    slave_read               = 1'b0;
    slave_write              = 1'b0;
    slave_chipselect         = 1'b0;
    slave_address            = '0;
    slave_writedata          = '0;
    slave_beginbursttransfer = 1'b0;
    slave_burstcount         = '0;
    dac_ready                = 1'b0;
    adc_valid                = 1'b0;
    adc_data                 = '0;
    i2c_busy                 = 1'b0;
    model_reset();
    @(negedge Clk);
    test_reset();
    test_i2c();
    test_dac_fill();
    test_adc_burst();
    test_overrun();
    test_random_traffic();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
